// File: rtl/nand_or_accumulator_if.sv
// Handshake bundle for nand_or_accumulator: beat input side and result output side.
// Optional out_parity signal exists only when NAND_OR_PARITY_EN is defined.
// slave = the accumulator block, master = the upstream/downstream agent driving it.
interface nand_or_accumulator_if #(
  parameter int WIDTH = 8,
  parameter int BEATS = 4
);
  localparam int CW = $clog2(BEATS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_or;
  logic [CW-1:0]    out_beats;
`ifdef NAND_OR_PARITY_EN
  logic             out_parity;
`endif

  modport slave (
    input  in_valid, in_a, in_b, flush, out_ready,
    output in_ready, out_valid, out_or, out_beats
`ifdef NAND_OR_PARITY_EN
    , output out_parity
`endif
  );

  modport master (
    output in_valid, in_a, in_b, flush, out_ready,
    input  in_ready, out_valid, out_or, out_beats
`ifdef NAND_OR_PARITY_EN
    , input out_parity
`endif
  );
endinterface

// File: rtl/nand_or_accumulator.sv
// OR-accumulates NAND-built per-beat ORs of in_a/in_b over BEATS beats (or until flush); optional out_parity via NAND_OR_PARITY_EN.
// Latency: result valid the cycle after the final beat's accept edge; one result per BEATS+1 cycles.
// Backpressure: while a result is held, in_ready=0 and the result stays stable until out_ready.
module nand_or_accumulator #(
  parameter int WIDTH = 8,
  parameter int BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nand_or_accumulator_if.slave  bus
);
  localparam int CW = $clog2(BEATS + 1);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  // Two-input NAND on vectors; the only gate used to build the OR.
  function automatic logic [WIDTH-1:0] nand2(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return ~(x & y);
  endfunction

  state_t         state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] out_or_q, out_or_d;
  logic [CW-1:0]  out_beats_q, out_beats_d;
`ifdef NAND_OR_PARITY_EN
  logic           out_parity_q, out_parity_d;
`endif

  logic [WIDTH-1:0] beat;
  logic [CW-1:0]    cnt_inc;
  logic             accept;

  // Per-beat OR from NANDs; acc only absorbs it on accept, so X operands while idle never reach state.
  always_comb begin
    beat    = nand2(nand2(bus.in_a, bus.in_a), nand2(bus.in_b, bus.in_b));
    cnt_inc = cnt_q + 1'b1;
    accept  = bus.in_valid && (state_q == ACCUM);
  end

  // Next-state and datapath updates for the ACCUM/HOLD machine.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_or_d    = out_or_q;
    out_beats_d = out_beats_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = acc_q | beat;
          cnt_d = cnt_inc;
          if ((cnt_inc == BEATS_C) || bus.flush) begin
            state_d     = HOLD;
            out_or_d    = acc_q | beat;
            out_beats_d = cnt_inc;
          end
        end else if (bus.flush && (cnt_q != '0)) begin
          // Early close with what has been gathered; an empty flush produces nothing.
          state_d     = HOLD;
          out_or_d    = acc_q;
          out_beats_d = cnt_q;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

`ifdef NAND_OR_PARITY_EN
  // Parity tracks the word being registered so it changes only with out_or.
  always_comb begin
    out_parity_d = ^out_or_d;
  end
`endif

  // State registers; reset discards any partial accumulation and any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_or_q     <= '0;
      out_beats_q  <= '0;
`ifdef NAND_OR_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_or_q     <= out_or_d;
      out_beats_q  <= out_beats_d;
`ifdef NAND_OR_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

  // Handshake outputs depend on state only.
  always_comb begin
    bus.in_ready   = (state_q == ACCUM);
    bus.out_valid  = (state_q == HOLD);
    bus.out_or     = out_or_q;
    bus.out_beats  = out_beats_q;
`ifdef NAND_OR_PARITY_EN
    bus.out_parity = out_parity_q;
`endif
  end

endmodule

// File: tb/tb_nand_or_accumulator.sv
// Directed bench for nand_or_accumulator (WIDTH=8, BEATS=4).
// Inputs driven 1 time unit after each rising edge; outputs checked at the same point.
// Expected values are hand-computed constants.
module tb_nand_or_accumulator;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  nand_or_accumulator_if #(.WIDTH(8), .BEATS(4)) bus ();

  nand_or_accumulator #(.WIDTH(8), .BEATS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    step();
    bus.in_valid = 1'b0;
    bus.in_a     = 8'hxx;
    bus.in_b     = 8'hxx;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'hxx;
    bus.in_b      = 8'hxx;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_or",    32'(bus.out_or),    32'd0);
    chk("rst_out_beats", 32'(bus.out_beats), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    rst = 1'b0;

    // Idle with X operands and in_valid low: nothing may go X.
    step();
    step();
    chk("idle_x_out_or",    32'(bus.out_or),    32'd0);
    chk("idle_x_out_valid", 32'(bus.out_valid), 32'd0);

    // Full run, out_ready high.
    bus.out_ready = 1'b1;
    beat(8'h01, 8'h00);
    beat(8'h00, 8'h02);
    beat(8'h04, 8'h08);
    chk("full_pre_valid", 32'(bus.out_valid), 32'd0);
    beat(8'h00, 8'h00);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    chk("full_out_or",    32'(bus.out_or),    32'h0F);
    chk("full_out_beats", 32'(bus.out_beats), 32'd4);
    chk("full_in_ready",  32'(bus.in_ready),  32'd0);
    step();
    chk("full_done_valid", 32'(bus.out_valid), 32'd0);
    chk("full_done_ready", 32'(bus.in_ready),  32'd1);

    // Same run with backpressure; beats and flush offered during HOLD are ignored.
    bus.out_ready = 1'b0;
    beat(8'h01, 8'h00);
    beat(8'h00, 8'h02);
    beat(8'h04, 8'h08);
    beat(8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.flush    = i[1];
      bus.in_a     = 8'hF0;
      bus.in_b     = 8'h0F;
      step();
      chk("bp_out_or",     32'(bus.out_or),    32'h0F);
      chk("bp_out_beats",  32'(bus.out_beats), 32'd4);
      chk("bp_in_ready",   32'(bus.in_ready),  32'd0);
      chk("bp_out_valid",  32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.in_a      = 8'hxx;
    bus.in_b      = 8'hxx;
    bus.out_ready = 1'b1;
    step();
    chk("bp_done_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_done_ready", 32'(bus.in_ready),  32'd1);

    // Early flush after two beats.
    bus.out_ready = 1'b0;
    beat(8'h80, 8'h00);
    beat(8'h00, 8'h01);
    chk("ef_pre_valid", 32'(bus.out_valid), 32'd0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("ef_out_valid", 32'(bus.out_valid), 32'd1);
    chk("ef_out_or",    32'(bus.out_or),    32'h81);
    chk("ef_out_beats", 32'(bus.out_beats), 32'd2);
    bus.out_ready = 1'b1;
    step();
    chk("ef_done_valid", 32'(bus.out_valid), 32'd0);

    // Flush with nothing gathered: no result.
    bus.flush = 1'b1;
    step();
    chk("empty_flush_valid1", 32'(bus.out_valid), 32'd0);
    step();
    bus.flush = 1'b0;
    chk("empty_flush_valid2", 32'(bus.out_valid), 32'd0);
    chk("empty_flush_ready",  32'(bus.in_ready),  32'd1);

    // Flush together with the first beat.
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    beat(8'hF0, 8'h0F);
    bus.flush = 1'b0;
    chk("fb_out_valid", 32'(bus.out_valid), 32'd1);
    chk("fb_out_or",    32'(bus.out_or),    32'hFF);
    chk("fb_out_beats", 32'(bus.out_beats), 32'd1);
    bus.out_ready = 1'b1;
    step();
    chk("fb_done_valid", 32'(bus.out_valid), 32'd0);

    // Reset mid-run with a beat offered on the reset edge; earlier beats are discarded.
    beat(8'hF0, 8'h00);
    beat(8'h00, 8'h80);
    beat(8'h30, 8'h00);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'hFF;
    bus.in_b     = 8'hFF;
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_out_or",    32'(bus.out_or),    32'd0);
    chk("mr_in_ready",  32'(bus.in_ready),  32'd1);
    beat(8'h01, 8'h00);
    beat(8'h00, 8'h02);
    beat(8'h04, 8'h00);
    chk("mr_pre_valid", 32'(bus.out_valid), 32'd0);
    beat(8'h00, 8'h00);
    chk("mr_res_valid", 32'(bus.out_valid), 32'd1);
    chk("mr_res_or",    32'(bus.out_or),    32'h07);
    chk("mr_res_beats", 32'(bus.out_beats), 32'd4);
`ifdef NAND_OR_PARITY_EN
    chk("mr_res_parity", 32'(bus.out_parity), 32'd1);
`endif
    step();
    chk("mr_done_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
